// File: rtl/pipeline_wake_ctrl_if.sv
// Upstream valid/ready word stream into pipeline_wake_ctrl.
interface pipeline_wake_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pipeline_wake_ctrl.sv
// FIFO front end that wakes, feeds and idle-gates a clock-gated pipeline.
// Optional statistics outputs are enabled by defining PIPE_WAKE_STATS_EN.
module pipeline_wake_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STAGES      = 4,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_wake_ctrl_if.slave      s,
    input  logic                     force_en,
    output logic                     pipe_en,
    output logic                     pipe_valid,
    output logic [WIDTH-1:0]         pipe_data,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef PIPE_WAKE_STATS_EN
   ,output logic [31:0]              gated_cycles,
    output logic [15:0]              wake_events
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(IDLE_CYCLES) + 1;
    localparam int unsigned WW = $clog2(WAKE_CYCLES) + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    generate
        if (IDLE_CYCLES < STAGES || WAKE_CYCLES < 1 || DEPTH < 2 ||
            (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
            $error("pipeline_wake_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAKE = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WW-1:0]    wake_cnt_q, wake_cnt_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pipe_en_q, pipe_en_d;
    logic             pipe_valid_q, pipe_valid_d;
    logic [WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic             ready;
    logic             push;
    logic             pop;

    // Readiness follows the registered count only, so a same-cycle pop never frees a slot early.
    assign ready     = (count_q != FULL);
    assign s.s_ready = ready;
    assign push      = s.s_valid && ready;
    assign pop       = (state_q == ST_RUN) && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (push || count_q != '0 || force_en) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (push || pop || force_en) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST && count_q == '0) begin
                    state_d = ST_IDLE;
                end else if (idle_cnt_q != IDLE_LAST) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pipe_en_d    = (state_d != ST_IDLE);
        pipe_valid_d = pop;
        pipe_data_d  = pop ? mem_q[rd_ptr_q] : pipe_data_q;
        count_d      = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pipe_en_q    <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
        end else begin
            count_q      <= count_d;
            pipe_en_q    <= pipe_en_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s.s_data;
    end

    assign pipe_en    = pipe_en_q;
    assign pipe_valid = pipe_valid_q;
    assign pipe_data  = pipe_data_q;
    assign state_o    = state_q;
    assign fifo_count = count_q;

`ifdef PIPE_WAKE_STATS_EN
    logic [31:0] gated_q;
    logic [15:0] wakes_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gated_q <= '0;
            wakes_q <= '0;
        end else begin
            if (!pipe_en_q && gated_q != '1) gated_q <= gated_q + 1'b1;
            if (state_q == ST_IDLE && state_d == ST_WAKE && wakes_q != '1)
                wakes_q <= wakes_q + 1'b1;
        end
    end

    assign gated_cycles = gated_q;
    assign wake_events  = wakes_q;
`endif
endmodule

// File: tb/tb_pipeline_wake_ctrl.sv
// Randomized plus directed bench for pipeline_wake_ctrl with a timestamp-based reference model.
module tb_pipeline_wake_ctrl;
    localparam int unsigned WIDTH       = 32;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned STAGES      = 4;
    localparam int unsigned IDLE_CYCLES = 8;
    localparam int unsigned WAKE_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             force_en = 1'b0;
    logic             pipe_en;
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;
    logic [1:0]       state_o;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef PIPE_WAKE_STATS_EN
    logic [31:0]      gated_cycles;
    logic [15:0]      wake_events;
`endif

    pipeline_wake_ctrl_if #(.WIDTH(WIDTH)) bus ();

    pipeline_wake_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .STAGES(STAGES),
        .IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .s(bus), .force_en(force_en),
        .pipe_en(pipe_en), .pipe_valid(pipe_valid), .pipe_data(pipe_data),
        .state_o(state_o), .fifo_count(fifo_count)
`ifdef PIPE_WAKE_STATS_EN
       ,.gated_cycles(gated_cycles), .wake_events(wake_events)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: word queue plus edge timestamps; mode uses the 00/01/10 output encoding.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               cyc = 0;
    int               run_at = 0;
    int               last_act = 0;
    int               m_mode = 0;
    bit               m_en = 1'b0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    longint unsigned  m_gated = 0;
    longint unsigned  m_wakes = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        exp_q.delete();
        m_mode = 0; m_en = 1'b0; m_valid = 1'b0; m_data = '0;
        m_gated = 0; m_wakes = 0;
    endtask

    // Drives one edge worth of inputs and advances the model to the state after that edge.
    task automatic step(input bit sv, input logic [WIDTH-1:0] sd, input bit fe, output bit acc);
        int sz;
        bit push, pop;
        @(negedge clk);
        bus.s_valid = sv; bus.s_data = sd; force_en = fe;
        cyc++;
        sz   = m_q.size();
        push = sv && (sz < int'(DEPTH));
        pop  = (m_mode == 2) && (sz > 0);
        if (!m_en && m_gated != 64'hFFFF_FFFF) m_gated++;
        if (pop) begin
            m_data = m_q.pop_front();
            exp_q.push_back(m_data);
        end
        m_valid = pop;
        if (push) m_q.push_back(sd);
        case (m_mode)
            0: if (push || sz > 0 || fe) begin
                   m_mode = 1;
                   run_at = cyc + int'(WAKE_CYCLES);
                   if (m_wakes != 64'hFFFF) m_wakes++;
               end
            1: if (cyc == run_at) begin m_mode = 2; last_act = cyc; end
            default: begin
                if (push || pop || fe) last_act = cyc;
                else if (cyc - last_act >= int'(IDLE_CYCLES)) m_mode = 0;
            end
        endcase
        m_en = (m_mode != 0);
        acc  = push;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit mid);
        chk_en = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; force_en = 1'b0;
        #1;
        if (mid) begin
            check("rst_state", state_o, 0);
            check("rst_pipe_en", pipe_en, 0);
            check("rst_pipe_valid", pipe_valid, 0);
            check("rst_fifo_count", fifo_count, 0);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_s_ready", bus.s_ready, 1);
        chk_en = 1'b1;
    endtask

    initial begin : monitor
        logic [WIDTH-1:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("state_o", state_o, longint'(m_mode));
                check("pipe_en", pipe_en, m_en);
                check("fifo_count", fifo_count, m_q.size());
                check("s_ready", bus.s_ready, m_q.size() < DEPTH);
                check("pipe_valid", pipe_valid, m_valid);
                if (pipe_valid && !pipe_en) check("valid_without_en", 1, 0);
                if (pipe_valid) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_word", pipe_data, 64'hDEAD_0000_0000);
                    end else begin
                        w = exp_q.pop_front();
                        check("pipe_data", pipe_data, w);
                    end
                end else begin
                    check("pipe_data_hold", pipe_data, m_data);
                end
`ifdef PIPE_WAKE_STATS_EN
                check("gated_cycles", gated_cycles, m_gated);
                check("wake_events", wake_events, m_wakes);
`endif
            end
        end
    end

    initial begin : stimulus
        bit a;
        int k;
        int pct;
        int len;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        do_reset(1'b0);

        // force_en held in IDLE with an empty FIFO
        step(1'b0, '0, 1'b1, a); sample();
        check("force_wake_state", state_o, 1);
        step(1'b0, '0, 1'b1, a); step(1'b0, '0, 1'b1, a); sample();
        check("force_run_state", state_o, 2);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, a);
        sample();
        check("force_hold_state", state_o, 2);
`ifdef PIPE_WAKE_STATS_EN
        check("force_wake_events", wake_events, 1);
`endif
        idle(7); sample();
        check("force_release_en_hi", pipe_en, 1);
        idle(1); sample();
        check("force_release_en_lo", pipe_en, 0);

        // single wake of 0x10 from IDLE
        step(1'b1, 32'h10, 1'b0, a); sample();
        check("wake_state", state_o, 1);
        check("wake_en", pipe_en, 1);
        idle(1); sample();
        check("wake_no_valid_e1", pipe_valid, 0);
        idle(1); sample();
        check("wake_run_e2", state_o, 2);
        check("wake_no_valid_e2", pipe_valid, 0);
        idle(1); sample();
        check("wake_valid_e3", pipe_valid, 1);
        check("wake_data_e3", pipe_data, 32'h10);

        // push lands on the final idle edge
        idle(7);
        step(1'b1, 32'hAB, 1'b0, a); sample();
        check("collide_state", state_o, 2);
        check("collide_en", pipe_en, 1);
        idle(1); sample();
        check("collide_valid", pipe_valid, 1);
        check("collide_data", pipe_data, 32'hAB);

        // idle timeout after the last pop
        idle(7); sample();
        check("timeout_en_t7", pipe_en, 1);
        idle(1); sample();
        check("timeout_en_t8", pipe_en, 0);
        check("timeout_state_t8", state_o, 0);

        // held s_valid with words 1..6 starting from IDLE
        k = 1;
        for (int i = 0; i < 40 && k <= 6; i++) begin
            step(1'b1, 32'(k), 1'b0, a);
            if (a) k++;
        end
        check("bp_all_accepted", k, 7);
        idle(16);

        // randomized traffic bursts, including long idle gaps
        for (int blk = 0; blk < 60; blk++) begin
            case ($urandom_range(0, 3))
                0: pct = 0;
                1: pct = 15;
                2: pct = 60;
                default: pct = 100;
            endcase
            len = int'($urandom_range(5, 40));
            for (int i = 0; i < len; i++)
                step(int'($urandom_range(0, 99)) < pct, $urandom, $urandom_range(0, 39) == 0, a);
        end

        // reset in the middle of traffic
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, a);
        do_reset(1'b1);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 1) == 1, $urandom, 1'b0, a);
        idle(20);
        sample();
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
